arbitro_mem_externa: RTL and testbench

ARBITRO_MEM_EXTERNA -- requirements
Module: arbitro_mem_externa

---
 rtl/arbitro_mem_pkg.sv | 20 ++
 rtl/arbitro_round_robin_2.sv | 35 +++
 rtl/arbitro_mem_externa.sv | 134 +++++++++++++
 tb/tb_arbitro_mem_externa.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_mem_pkg.sv
// rtl/arbitro_mem_pkg.sv - shared state encodings and default widths for the external memory arbiter
package arbitro_mem_pkg;

  localparam int BITS_BUS_DATOS_INSTR_DEF = 21;
  localparam int BITS_DATOS_DEF           = 32;

  typedef enum logic [2:0] {
    E_LIBRE          = 3'd0,
    E_LECTURA        = 3'd1,
    E_ESPERA_LECTURA = 3'd2,
    E_ESCRITURA      = 3'd3,
    E_FIN            = 3'd4
  } estado_t;

  typedef enum logic {
    G_LECTURA   = 1'b0,
    G_ESCRITURA = 1'b1
  } concesion_t;

endpackage

// File: rtl/arbitro_round_robin_2.sv
// rtl/arbitro_round_robin_2.sv - two-way round-robin grant choice with last-grant register
module arbitro_round_robin_2
  import arbitro_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       grant_en,
  output logic       grant_valid,
  output concesion_t grant
);

  concesion_t ultimo;

  // Starting from "write" makes the first contention after reset go to the reader.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ultimo <= G_ESCRITURA;
    end else if (grant_en && grant_valid) begin
      ultimo <= grant;
    end
  end

  always_comb begin
    grant_valid = rd_req | wr_req;
    grant       = G_LECTURA;
    if (rd_req && wr_req) begin
      grant = (ultimo == G_LECTURA) ? G_ESCRITURA : G_LECTURA;
    end else if (wr_req) begin
      grant = G_ESCRITURA;
    end
  end

endmodule

// File: rtl/arbitro_mem_externa.sv
// rtl/arbitro_mem_externa.sv - arbitrates one reader and one writer onto a single external memory port
module arbitro_mem_externa
  import arbitro_mem_pkg::*;
#(
  parameter int BITS_BUS_DATOS_INSTR = BITS_BUS_DATOS_INSTR_DEF,
  parameter int BITS_DATOS           = BITS_DATOS_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_req,
  input  logic [BITS_BUS_DATOS_INSTR-1:0] rd_address,
  output logic                            rd_done,
  output logic [BITS_DATOS-1:0]           rd_data,
  input  logic                            wr_req,
  input  logic [BITS_BUS_DATOS_INSTR-1:0] wr_address,
  input  logic [BITS_DATOS-1:0]           wr_data,
  output logic                            wr_done,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [BITS_BUS_DATOS_INSTR-1:0] mem_address,
  output logic [BITS_DATOS-1:0]           mem_writedata,
  input  logic                            mem_waitrequest,
  input  logic                            mem_readdatavalid,
  input  logic [BITS_DATOS-1:0]           mem_readdata,
  output logic                            busy
);

  estado_t                         estado, estado_sig;
  logic                            en_libre;
  logic                            grant_valid;
  concesion_t                      grant;
  logic                            es_escritura;
  logic                            captura_lectura;
  logic [BITS_BUS_DATOS_INSTR-1:0] direccion_q;
  logic [BITS_DATOS-1:0]           dato_escr_q;
  logic [BITS_DATOS-1:0]           rd_data_q;

  assign en_libre = (estado == E_LIBRE);

  arbitro_round_robin_2 u_round_robin (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .grant_en    (en_libre),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Read data is only taken once the command has been accepted; stray valids elsewhere are dropped.
  assign captura_lectura = ((estado == E_LECTURA) && !mem_waitrequest && mem_readdatavalid) ||
                           ((estado == E_ESPERA_LECTURA) && mem_readdatavalid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= E_LIBRE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      es_escritura <= 1'b0;
      direccion_q  <= '0;
      dato_escr_q  <= '0;
      rd_data_q    <= '0;
    end else begin
      if (en_libre && grant_valid) begin
        es_escritura <= (grant == G_ESCRITURA);
        if (grant == G_ESCRITURA) begin
          direccion_q <= wr_address;
          dato_escr_q <= wr_data;
        end else begin
          direccion_q <= rd_address;
        end
      end
      if (captura_lectura) begin
        rd_data_q <= mem_readdata;
      end
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      E_LIBRE: begin
        if (grant_valid) begin
          estado_sig = (grant == G_ESCRITURA) ? E_ESCRITURA : E_LECTURA;
        end
      end
      E_LECTURA: begin
        if (!mem_waitrequest) begin
          estado_sig = mem_readdatavalid ? E_FIN : E_ESPERA_LECTURA;
        end
      end
      E_ESPERA_LECTURA: begin
        if (mem_readdatavalid) begin
          estado_sig = E_FIN;
        end
      end
      E_ESCRITURA: begin
        if (!mem_waitrequest) begin
          estado_sig = E_FIN;
        end
      end
      E_FIN:   estado_sig = E_LIBRE;
      default: estado_sig = E_LIBRE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    busy      = 1'b1;
    case (estado)
      E_LIBRE:     busy      = 1'b0;
      E_LECTURA:   mem_read  = 1'b1;
      E_ESCRITURA: mem_write = 1'b1;
      E_FIN: begin
        rd_done = !es_escritura;
        wr_done = es_escritura;
      end
      default: ;
    endcase
  end

  assign rd_data       = rd_data_q;
  assign mem_address   = direccion_q;
  assign mem_writedata = dato_escr_q;

endmodule

// File: tb/tb_arbitro_mem_externa.sv
// tb/tb_arbitro_mem_externa.sv - randomized self-checking bench for arbitro_mem_externa
module tb_arbitro_mem_externa;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req, wr_req;
  logic [20:0] rd_address, wr_address;
  logic [31:0] wr_data;
  logic        rd_done, wr_done, busy;
  logic [31:0] rd_data;
  logic        mem_read, mem_write;
  logic [20:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest, mem_readdatavalid;
  logic [31:0] mem_readdata;

  logic        slave_en, mon_en, cfg_rand;
  int          cfg_ws, cfg_vd, phase_kind;
  logic [31:0] cfg_data;
  logic        s_wait, s_valid, m_wait, m_valid;
  logic [31:0] s_data, m_data;

  int n_checks = 0;
  int n_pass   = 0;

  int n_rd_cyc = 0, n_wr_cyc = 0, n_rd_done = 0, n_wr_done = 0;
  int both_hi = 0, unstable = 0;
  int last_lat;

  logic [20:0] rd_addr_arr [256];
  logic [52:0] wr_arr      [256];
  logic [31:0] dat_arr     [256];
  int rd_push = 0, wr_push = 0, dat_push = 0;
  int rd_pop  = 0, wr_pop  = 0, dat_pop  = 0;

  assign mem_waitrequest   = slave_en ? s_wait  : m_wait;
  assign mem_readdatavalid = slave_en ? s_valid : m_valid;
  assign mem_readdata      = slave_en ? s_data  : m_data;

  arbitro_mem_externa #(.BITS_BUS_DATOS_INSTR(21), .BITS_DATOS(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .rd_req            (rd_req),
    .rd_address        (rd_address),
    .rd_done           (rd_done),
    .rd_data           (rd_data),
    .wr_req            (wr_req),
    .wr_address        (wr_address),
    .wr_data           (wr_data),
    .wr_done           (wr_done),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory slave: random or configured wait states and read-valid delay per command.
  initial begin
    int          ws, vd;
    logic        is_rd;
    logic [31:0] dat;
    s_wait = 1'b0; s_valid = 1'b0; s_data = '0;
    forever begin
      @(negedge clk);
      s_valid = 1'b0;
      if (slave_en && reset && (mem_read || mem_write)) begin
        is_rd = mem_read;
        ws  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_ws;
        vd  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_vd;
        dat = cfg_rand ? $urandom : cfg_data;
        if (is_rd) begin
          dat_arr[dat_push % 256] = dat;
          dat_push++;
        end
        for (int i = 0; i < ws; i++) begin
          s_wait = 1'b1;
          @(negedge clk);
        end
        s_wait = 1'b0;
        if (is_rd) begin
          for (int i = 0; i < vd; i++) @(negedge clk);
          s_valid = 1'b1;
          s_data  = dat;
        end
      end
    end
  end

  // Reference model: transaction order from the round-robin rule, expected payloads from requesters.
  logic        cmd_prev = 1'b0;
  logic        model_last = 1'b1;
  logic [20:0] cur_addr;
  logic [31:0] cur_wdata;
  always @(negedge clk) begin
    logic cmd_now, exp_wr;
    cmd_now = mem_read | mem_write;
    if (!reset) model_last = 1'b1;
    if (mem_read && mem_write) both_hi++;
    if (mem_read)  n_rd_cyc++;
    if (mem_write) n_wr_cyc++;
    if (rd_done)   n_rd_done++;
    if (wr_done)   n_wr_done++;
    if (mon_en && cmd_now && cmd_prev && (mem_address != cur_addr || mem_writedata != cur_wdata))
      unstable++;
    if (mon_en && cmd_now && !cmd_prev) begin
      exp_wr = (phase_kind == 2) ? !model_last : (phase_kind == 1);
      check("grant_type", 64'(mem_write), 64'(exp_wr));
      model_last = exp_wr;
      if (mem_write) begin
        check("wr_queue", 64'(wr_pop < wr_push), 64'd1);
        check("wr_addr", 64'(mem_address), 64'(wr_arr[wr_pop % 256][52:32]));
        check("wr_data", 64'(mem_writedata), 64'(wr_arr[wr_pop % 256][31:0]));
        wr_pop++;
      end else begin
        check("rd_queue", 64'(rd_pop < rd_push), 64'd1);
        check("rd_addr", 64'(mem_address), 64'(rd_addr_arr[rd_pop % 256]));
        rd_pop++;
      end
    end
    if (mon_en && rd_done) begin
      check("rd_data", 64'(rd_data), 64'(dat_arr[dat_pop % 256]));
      dat_pop++;
    end
    cur_addr  = mem_address;
    cur_wdata = mem_writedata;
    cmd_prev  = cmd_now;
  end

  task automatic do_read(input logic [20:0] a);
    int n;
    rd_addr_arr[rd_push % 256] = a;
    rd_push++;
    rd_address = a;
    rd_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_done && n < 100);
    if (n >= 100) check("rd_timeout", 64'd1, 64'd0);
    rd_req = 1'b0;
    last_lat = n;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] d);
    int n;
    wr_arr[wr_push % 256] = {a, d};
    wr_push++;
    wr_address = a;
    wr_data = d;
    wr_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_done && n < 100);
    if (n >= 100) check("wr_timeout", 64'd1, 64'd0);
    wr_req = 1'b0;
    last_lat = n;
  endtask

  task automatic rd_loop(input int cnt);
    for (int i = 0; i < cnt; i++) do_read(21'($urandom));
  endtask

  task automatic wr_loop(input int cnt);
    for (int i = 0; i < cnt; i++) do_write(21'($urandom), $urandom);
  endtask

  initial begin
    int rc, dc, wc, wd;
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_address = '0; wr_address = '0; wr_data = '0;
    slave_en = 1'b1; mon_en = 1'b1; cfg_rand = 1'b0; phase_kind = 0;
    cfg_ws = 0; cfg_vd = 0; cfg_data = '0;
    m_wait = 1'b0; m_valid = 1'b0; m_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
    check("rst_done", 64'({rd_done, wr_done}), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_mem_addr", 64'(mem_address), 64'd0);
    check("rst_mem_wdata", 64'(mem_writedata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    phase_kind = 0; cfg_ws = 0; cfg_vd = 3; cfg_data = 32'hCAFEF00D;
    rc = n_rd_cyc; dc = n_rd_done;
    do_read(21'h100);
    repeat (3) @(negedge clk);
    check("rd_cmd_cycles", 64'(n_rd_cyc - rc), 64'd1);
    check("rd_done_pulses", 64'(n_rd_done - dc), 64'd1);
    check("rd_data_cafe", 64'(rd_data), 64'hCAFEF00D);

    phase_kind = 1; cfg_ws = 2;
    wc = n_wr_cyc; wd = n_wr_done;
    do_write(21'h200, 32'h12345678);
    repeat (3) @(negedge clk);
    check("wr_cmd_cycles", 64'(n_wr_cyc - wc), 64'd3);
    check("wr_done_pulses", 64'(n_wr_done - wd), 64'd1);

    slave_en = 1'b0; dc = n_rd_done; wd = n_wr_done;
    m_valid = 1'b1; m_data = 32'hFFFFFFFF;
    @(negedge clk);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_rd_data", 64'(rd_data), 64'hCAFEF00D);
    check("spur_no_done", 64'((n_rd_done - dc) + (n_wr_done - wd)), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);
    slave_en = 1'b1;

    phase_kind = 0; cfg_ws = 0; cfg_vd = 0; cfg_data = $urandom;
    do_read(21'($urandom));
    check("rd_latency", 64'(last_lat), 64'd2);
    @(negedge clk);
    phase_kind = 1;
    do_write(21'($urandom), $urandom);
    check("wr_latency", 64'(last_lat), 64'd2);
    @(negedge clk);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst2_rd_data", 64'(rd_data), 64'd0);
    phase_kind = 2; cfg_rand = 1'b1;
    fork
      rd_loop(3);
      wr_loop(3);
    join
    repeat (2) @(negedge clk);
    fork
      rd_loop(12);
      wr_loop(12);
    join
    repeat (3) @(negedge clk);
    check("rd_all_issued", 64'(rd_pop), 64'(rd_push));
    check("wr_all_issued", 64'(wr_pop), 64'(wr_push));

    slave_en = 1'b0; mon_en = 1'b0; cfg_rand = 1'b0;
    m_wait = 1'b0; m_valid = 1'b0;
    rd_address = 21'h55; rd_req = 1'b1;
    @(negedge clk);
    check("abort_in_read", 64'(mem_read), 64'd1);
    rd_req = 1'b0;
    @(negedge clk);
    check("abort_wait_busy", 64'({busy, mem_read}), 64'b10);
    dc = n_rd_done;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; m_valid = 1'b1; m_data = 32'hDEADBEEF;
    @(negedge clk);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", 64'(n_rd_done - dc), 64'd0);
    check("abort_rd_data", 64'(rd_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);

    check("never_rd_and_wr", 64'(both_hi), 64'd0);
    check("cmd_stable", 64'(unstable), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
